// File: rtl/pipeline_pkg.sv
// Shared definitions for the commit stage: FSM encoding, default widths,
// exception stage indices and a select-width helper.
package pipeline_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_RIDX_W = 5;

  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_ALU    = 2;
  localparam int STG_MEM    = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_LATE = 2'd1,
    TRAPPED   = 2'd2
  } state_e;

  // Index width for an n-way select; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_commit_if.sv
// Commit-stage bus: instruction arriving at commit, late-unit handshake,
// trap acknowledge, and the regfile write port / trap status driven back.
interface pipeline_commit_if
  import pipeline_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RIDX_W = DEF_RIDX_W,
  parameter int NSTAGE = 4,
  parameter int EXC_W  = 3,
  parameter int NSRC   = 3,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = sel_width(NSRC);
  localparam int STG_W = sel_width(NSTAGE);

  logic                      in_valid;
  logic [XLEN-1:0]           in_pc;
  logic [NSTAGE*EXC_W-1:0]   in_exc;
  logic [RIDX_W-1:0]         rd_index;
  logic                      regwrite_enable;
  logic [SEL_W-1:0]          src_sel;
  logic [NSRC*XLEN-1:0]      src_data;
  logic                      late_pending;
  logic                      late_valid;
  logic [XLEN-1:0]           late_result;
  logic                      exc_ack;

  logic                      stall;
  logic                      we;
  logic [RIDX_W-1:0]         windex;
  logic [XLEN-1:0]           win;
  logic [NSTAGE*EXC_W-1:0]   final_exception;
  logic                      exc_valid;
  logic [STG_W-1:0]          exc_stage;
  logic [XLEN-1:0]           exc_pc;
  logic [CNT_W-1:0]          retire_count;

  modport master (
    output in_valid, in_pc, in_exc, rd_index, regwrite_enable, src_sel, src_data,
           late_pending, late_valid, late_result, exc_ack,
    input  stall, we, windex, win, final_exception, exc_valid, exc_stage, exc_pc,
           retire_count
  );

  modport slave (
    input  in_valid, in_pc, in_exc, rd_index, regwrite_enable, src_sel, src_data,
           late_pending, late_valid, late_result, exc_ack,
    output stall, we, windex, win, final_exception, exc_valid, exc_stage, exc_pc,
           retire_count
  );

endinterface

// File: rtl/pipeline_commit_exc_prio_enc.sv
// Exception priority encoder: flags any nonzero per-stage cause and reports
// the earliest (lowest-index) faulting stage. Purely combinational.
module exc_prio_enc
  import pipeline_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int EXC_W  = 3,
  parameter int STG_W  = sel_width(NSTAGE)
) (
  input  logic [NSTAGE*EXC_W-1:0] exc_vec,
  output logic                    any_exc,
  output logic [STG_W-1:0]        stage_idx
);

  // NOTE: every output gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    any_exc   = 1'b0;
    stage_idx = '0;
    // Scan from the latest stage down so the earliest fault is written last.
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (|exc_vec[s*EXC_W +: EXC_W]) begin
        any_exc   = 1'b1;
        stage_idx = STG_W'(s);
      end
    end
  end

endmodule

// File: rtl/pipeline_commit.sv
// Final pipeline stage: selects the result, drives the regfile write port,
// waits on late results, latches the first exception until acknowledged.
module pipeline_commit
  import pipeline_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RIDX_W = DEF_RIDX_W,
  parameter int NSTAGE = 4,
  parameter int EXC_W  = 3,
  parameter int NSRC   = 3,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst,
  pipeline_commit_if.slave  bus
);

  localparam int SEL_W   = sel_width(NSRC);
  localparam int STG_W   = sel_width(NSTAGE);
  localparam int EXC_TOT = NSTAGE * EXC_W;

  state_e              state_q, state_d;
  logic                exc_valid_q, exc_valid_d;
  logic [STG_W-1:0]    exc_stage_q, exc_stage_d;
  logic [XLEN-1:0]     exc_pc_q, exc_pc_d;
  logic [EXC_TOT-1:0]  exc_vec_q, exc_vec_d;
  logic [CNT_W-1:0]    retire_q, retire_d;
  logic [RIDX_W-1:0]   pend_rd_q, pend_rd_d;
  logic                pend_we_q, pend_we_d;

  logic                any_exc;
  logic                exc_in;
  logic [STG_W-1:0]    enc_stage;
  logic [XLEN-1:0]     early_res;
  logic                we, stall;
  logic [RIDX_W-1:0]   windex;
  logic [XLEN-1:0]     win;

  exc_prio_enc #(
    .NSTAGE (NSTAGE),
    .EXC_W  (EXC_W),
    .STG_W  (STG_W)
  ) u_enc (
    .exc_vec   (bus.in_exc),
    .any_exc   (any_exc),
    .stage_idx (enc_stage)
  );

  assign exc_in = bus.in_valid && any_exc;

  // Out-of-range selects fall through to zero.
  always_comb begin
    early_res = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.src_sel == SEL_W'(k)) early_res = bus.src_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d     = state_q;
    exc_valid_d = exc_valid_q;
    exc_stage_d = exc_stage_q;
    exc_pc_d    = exc_pc_q;
    exc_vec_d   = exc_vec_q;
    retire_d    = retire_q;
    pend_rd_d   = pend_rd_q;
    pend_we_d   = pend_we_q;
    we          = 1'b0;
    stall       = 1'b0;
    windex      = bus.rd_index;
    win         = early_res;

    unique case (state_q)
      RUN: begin
        if (exc_in) begin
          exc_vec_d   = bus.in_exc;
          exc_stage_d = enc_stage;
          exc_pc_d    = bus.in_pc;
          exc_valid_d = 1'b1;
          state_d     = TRAPPED;
        end else if (bus.in_valid && bus.late_pending) begin
          stall     = 1'b1;
          pend_rd_d = bus.rd_index;
          pend_we_d = bus.regwrite_enable;
          state_d   = WAIT_LATE;
        end else if (bus.in_valid) begin
          we       = bus.regwrite_enable && (bus.rd_index != '0);
          retire_d = retire_q + CNT_W'(1);
        end
      end

      // The waiting instruction already cleared every exception check.
      WAIT_LATE: begin
        windex = pend_rd_q;
        win    = bus.late_result;
        if (bus.late_valid) begin
          we       = pend_we_q && (pend_rd_q != '0);
          retire_d = retire_q + CNT_W'(1);
          state_d  = RUN;
        end else begin
          stall = 1'b1;
        end
      end

      // Shadow instructions are flushed; ack takes precedence over new faults.
      TRAPPED: begin
        if (bus.exc_ack) begin
          exc_valid_d = 1'b0;
          exc_vec_d   = '0;
          exc_stage_d = '0;
          exc_pc_d    = '0;
          state_d     = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      exc_valid_q <= 1'b0;
      exc_stage_q <= '0;
      exc_pc_q    <= '0;
      exc_vec_q   <= '0;
      retire_q    <= '0;
      pend_rd_q   <= '0;
      pend_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exc_valid_q <= exc_valid_d;
      exc_stage_q <= exc_stage_d;
      exc_pc_q    <= exc_pc_d;
      exc_vec_q   <= exc_vec_d;
      retire_q    <= retire_d;
      pend_rd_q   <= pend_rd_d;
      pend_we_q   <= pend_we_d;
    end
  end

  assign bus.stall           = stall;
  assign bus.we              = we;
  assign bus.windex          = windex;
  assign bus.win             = win;
  assign bus.final_exception = exc_valid_q ? exc_vec_q : bus.in_exc;
  assign bus.exc_valid       = exc_valid_q;
  assign bus.exc_stage       = exc_stage_q;
  assign bus.exc_pc          = exc_pc_q;
  assign bus.retire_count    = retire_q;

endmodule

// File: tb/tb_pipeline_commit.sv
// Directed bench for pipeline_commit: main instance at default widths plus a
// 4-bit-counter twin sharing the same stimulus for the wrap-around case.
module tb_pipeline_commit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_commit_if bus ();
  pipeline_commit_if #(.CNT_W(4)) bus4 ();

  pipeline_commit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipeline_commit #(.CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  assign bus4.in_valid        = bus.in_valid;
  assign bus4.in_pc           = bus.in_pc;
  assign bus4.in_exc          = bus.in_exc;
  assign bus4.rd_index        = bus.rd_index;
  assign bus4.regwrite_enable = bus.regwrite_enable;
  assign bus4.src_sel         = bus.src_sel;
  assign bus4.src_data        = bus.src_data;
  assign bus4.late_pending    = bus.late_pending;
  assign bus4.late_valid      = bus.late_valid;
  assign bus4.late_result     = bus.late_result;
  assign bus4.exc_ack         = bus.exc_ack;

  int total = 0;
  int bad   = 0;
  int exp_cnt;
  int stall_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; samples taken 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid        = 1'b0;
    bus.in_pc           = '0;
    bus.in_exc          = '0;
    bus.rd_index        = '0;
    bus.regwrite_enable = 1'b0;
    bus.src_sel         = '0;
    bus.late_pending    = 1'b0;
    bus.late_valid      = 1'b0;
    bus.late_result     = '0;
    bus.exc_ack         = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic en, input logic [1:0] sel);
    idle();
    bus.in_valid        = 1'b1;
    bus.rd_index        = rd;
    bus.regwrite_enable = en;
    bus.src_sel         = sel;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    bus.src_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    do_reset();

    #2;
    check("rst_exc_valid", bus.exc_valid, 0);
    check("rst_exc_stage", bus.exc_stage, 0);
    check("rst_exc_pc", bus.exc_pc, 0);
    check("rst_retire", bus.retire_count, 0);
    check("rst_we", bus.we, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_final_exc", bus.final_exception, 0);
    tick();

    // Early-source writes, including an out-of-range select.
    issue(5'd5, 1'b1, 2'd1);
    #2;
    check("w1_we", bus.we, 1);
    check("w1_windex", bus.windex, 5);
    check("w1_win", bus.win, 32'hDEAD_BEEF);
    check("w1_stall", bus.stall, 0);
    tick();
    exp_cnt++;
    check("w1_retire", bus.retire_count, exp_cnt);

    issue(5'd2, 1'b1, 2'd0);
    #2;
    check("w2_win", bus.win, 32'h1111_1111);
    tick();
    exp_cnt++;

    issue(5'd9, 1'b1, 2'd2);
    #2;
    check("w3_win", bus.win, 32'h3333_3333);
    check("w3_windex", bus.windex, 9);
    tick();
    exp_cnt++;

    issue(5'd3, 1'b1, 2'd3);
    #2;
    check("w4_sel_oob_win", bus.win, 0);
    check("w4_we", bus.we, 1);
    tick();
    exp_cnt++;

    issue(5'd0, 1'b1, 2'd0);
    #2;
    check("rd0_we", bus.we, 0);
    tick();
    exp_cnt++;
    check("rd0_retire", bus.retire_count, exp_cnt);

    issue(5'd6, 1'b0, 2'd0);
    #2;
    check("noen_we", bus.we, 0);
    tick();
    exp_cnt++;

    idle();
    #2;
    check("idle_we", bus.we, 0);
    tick();
    check("idle_retire", bus.retire_count, exp_cnt);

    // Late result: issue cycle + 3 wait cycles stall, late_valid on the 5th.
    issue(5'd7, 1'b1, 2'd0);
    bus.late_pending = 1'b1;
    stall_cycles = 0;
    #2;
    if (bus.stall) stall_cycles++;
    check("late_issue_we", bus.we, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.in_valid = 1'b1;
      bus.in_exc   = 12'h004;
      #2;
      if (bus.stall) stall_cycles++;
      check("late_wait_we", bus.we, 0);
      tick();
    end
    check("late_stall_cycles", stall_cycles, 4);
    idle();
    bus.late_valid  = 1'b1;
    bus.late_result = 32'h0000_1234;
    #2;
    check("late_we", bus.we, 1);
    check("late_windex", bus.windex, 7);
    check("late_win", bus.win, 32'h0000_1234);
    check("late_stall", bus.stall, 0);
    tick();
    exp_cnt++;
    check("late_retire", bus.retire_count, exp_cnt);
    check("late_no_trap", bus.exc_valid, 0);

    idle();
    bus.late_valid = 1'b1;
    #2;
    check("stray_late_we", bus.we, 0);
    tick();
    check("stray_late_retire", bus.retire_count, exp_cnt);

    // Exception at stages 2 and 3: stage 2 is the earliest.
    issue(5'd4, 1'b1, 2'd0);
    bus.in_exc = 12'h280;
    bus.in_pc  = 32'h400;
    #2;
    check("exc_we", bus.we, 0);
    check("exc_final_fast", bus.final_exception, 12'h280);
    tick();
    idle();
    #2;
    check("exc_valid", bus.exc_valid, 1);
    check("exc_stage", bus.exc_stage, 2);
    check("exc_pc", bus.exc_pc, 32'h400);
    check("exc_final_latched", bus.final_exception, 12'h280);
    check("exc_no_retire", bus.retire_count, exp_cnt);

    issue(5'd4, 1'b1, 2'd0);
    bus.in_exc = 12'h004;
    bus.in_pc  = 32'h404;
    #2;
    check("trap2_we", bus.we, 0);
    check("trap2_final", bus.final_exception, 12'h280);
    tick();
    check("trap2_pc_kept", bus.exc_pc, 32'h400);
    check("trap2_stage_kept", bus.exc_stage, 2);

    issue(5'd6, 1'b1, 2'd0);
    #2;
    check("trap_flush_we", bus.we, 0);
    check("trap_flush_stall", bus.stall, 0);
    tick();
    check("trap_flush_retire", bus.retire_count, exp_cnt);

    issue(5'd4, 1'b1, 2'd0);
    bus.in_exc  = 12'h004;
    bus.exc_ack = 1'b1;
    #2;
    check("ack_we", bus.we, 0);
    tick();
    idle();
    #2;
    check("ack_exc_valid", bus.exc_valid, 0);
    check("ack_final", bus.final_exception, 0);
    check("ack_retire", bus.retire_count, exp_cnt);

    issue(5'd8, 1'b1, 2'd0);
    #2;
    check("post_ack_we", bus.we, 1);
    check("post_ack_windex", bus.windex, 8);
    tick();
    exp_cnt++;
    check("post_ack_retire", bus.retire_count, exp_cnt);

    idle();
    bus.exc_ack = 1'b1;
    tick();
    check("stray_ack_valid", bus.exc_valid, 0);

    // Fault at stage 0 alone.
    issue(5'd1, 1'b1, 2'd0);
    bus.in_exc = 12'h001;
    bus.in_pc  = 32'h500;
    tick();
    idle();
    #2;
    check("stg0_stage", bus.exc_stage, 0);
    check("stg0_pc", bus.exc_pc, 32'h500);
    bus.exc_ack = 1'b1;
    tick();
    idle();

    // Counter wrap on the 4-bit twin.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(5'(i % 31 + 1), 1'b1, 2'd0);
      tick();
      exp_cnt++;
    end
    idle();
    #2;
    check("wrap_cnt4", bus4.retire_count, 4'(exp_cnt));
    check("wrap_cnt4_lit", bus4.retire_count, 1);
    check("wrap_cnt32", bus.retire_count, 17);
    tick();

    // Reset while waiting on a late result drops the pending write.
    issue(5'd7, 1'b1, 2'd0);
    bus.late_pending = 1'b1;
    tick();
    idle();
    #2;
    check("mid_wait_stall", bus.stall, 1);
    do_reset();
    #2;
    check("mid_rst_stall", bus.stall, 0);
    bus.late_valid  = 1'b1;
    bus.late_result = 32'hABCD;
    #1;
    check("mid_rst_we", bus.we, 0);
    tick();
    idle();
    check("mid_rst_retire", bus.retire_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
